pmem_arbiter: RTL and testbench

Two-master arbiter and sequencer in front of the DPI-C physical-memory model. It accepts instruction-fetch reads from the IFU and load/store requests from the LSU over valid/ready handshakes. It grants one master at a time with round-robin tie-breaking and inserts a programmable access latency. It then drives a single one-cycle strobe to the memory model and returns the result on a registered response channel held until accepted.

---
 rtl/pmem_arbiter_if.sv | 49 ++++
 rtl/pmem_arbiter.sv | 126 ++++++++++++
 tb/tb_pmem_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmem_arbiter_if.sv
// Bus bundle for pmem_arbiter: IFU request/response, LSU request/response and
// the single-port strobe interface to the physical-memory model.
interface pmem_arbiter_if;
    // IFU channel
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic        ifu_resp_valid;
    logic        ifu_resp_ready;
    logic [31:0] ifu_resp_data;
    // LSU channel
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_resp_valid;
    logic        lsu_resp_ready;
    logic [31:0] lsu_resp_data;
    // Memory model side
    logic        mem_valid;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_rdata;

    // Environment side: requesters plus the memory model.
    modport master (
        output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        output lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        output lsu_resp_ready, mem_rdata,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );

    // Arbiter side.
    modport slave (
        input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
        input  lsu_req_valid, lsu_req_wen, lsu_req_addr, lsu_req_wdata, lsu_req_wmask,
        input  lsu_resp_ready, mem_rdata,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_valid, mem_wen, mem_raddr, mem_waddr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/pmem_arbiter.sv
// pmem_arbiter: round-robin arbiter between IFU and LSU in front of the
// physical-memory model. One transaction at a time: accept, wait LATENCY
// cycles, strobe memory for one cycle, then hold the response until taken.
module pmem_arbiter #(
    parameter int unsigned LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    pmem_arbiter_if.slave bus
);
    localparam int unsigned LatM1   = (LATENCY == 0) ? 0 : LATENCY - 1;
    localparam logic [3:0]  CntInit = LatM1[3:0];

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_last_lsu;
    logic        r_owner_lsu;
    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_resp_data;
    logic        r_mem_valid;
    logic        r_ifu_resp_valid;
    logic        r_lsu_resp_valid;

    logic w_idle;
    logic w_grant_lsu;
    logic w_accept;
    logic w_resp_hs;

    assign w_idle = (r_state == StIdle);

    // Grant: a lone requester wins; on a tie the master not served last wins.
    always_comb begin
        w_grant_lsu = 1'b0;
        if (bus.ifu_req_valid && bus.lsu_req_valid) begin
            w_grant_lsu = ~r_last_lsu;
        end else begin
            w_grant_lsu = bus.lsu_req_valid;
        end
    end

    assign bus.ifu_req_ready = w_idle && !w_grant_lsu;
    assign bus.lsu_req_ready = w_idle && w_grant_lsu;
    assign w_accept          = w_idle && (bus.ifu_req_valid || bus.lsu_req_valid);
    assign w_resp_hs         = (r_ifu_resp_valid && bus.ifu_resp_ready) ||
                               (r_lsu_resp_valid && bus.lsu_resp_ready);

    // Memory strobe outputs are forced to zero outside the access cycle.
    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_wen   = r_mem_valid && r_wen;
    assign bus.mem_raddr = r_mem_valid ? r_addr : '0;
    assign bus.mem_waddr = r_mem_valid ? r_addr : '0;
    assign bus.mem_wdata = r_mem_valid ? r_wdata : '0;
    assign bus.mem_wmask = r_mem_valid ? {4'b0000, r_wmask} : 8'h00;

    assign bus.ifu_resp_valid = r_ifu_resp_valid;
    assign bus.lsu_resp_valid = r_lsu_resp_valid;
    assign bus.ifu_resp_data  = r_resp_data;
    assign bus.lsu_resp_data  = r_resp_data;

    // Sequencer FSM with registered strobe and response-valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= StIdle;
            r_cnt            <= 4'd0;
            r_last_lsu       <= 1'b1;
            r_owner_lsu      <= 1'b0;
            r_wen            <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_wmask          <= '0;
            r_resp_data      <= '0;
            r_mem_valid      <= 1'b0;
            r_ifu_resp_valid <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_owner_lsu <= w_grant_lsu;
                        r_last_lsu  <= w_grant_lsu;
                        r_addr      <= w_grant_lsu ? bus.lsu_req_addr : bus.ifu_req_addr;
                        r_wen       <= w_grant_lsu && bus.lsu_req_wen;
                        // IFU carries no write payload.
                        r_wdata     <= w_grant_lsu ? bus.lsu_req_wdata : '0;
                        r_wmask     <= w_grant_lsu ? bus.lsu_req_wmask : '0;
                        r_cnt       <= CntInit;
                        if (LATENCY == 0) begin
                            r_state     <= StAccess;
                            r_mem_valid <= 1'b1;
                        end else begin
                            r_state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= StAccess;
                        r_mem_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                StAccess: begin
                    r_resp_data      <= r_wen ? '0 : bus.mem_rdata;
                    r_mem_valid      <= 1'b0;
                    r_ifu_resp_valid <= !r_owner_lsu;
                    r_lsu_resp_valid <= r_owner_lsu;
                    r_state          <= StResp;
                end
                StResp: begin
                    if (w_resp_hs) begin
                        r_ifu_resp_valid <= 1'b0;
                        r_lsu_resp_valid <= 1'b0;
                        r_state          <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Testbench for pmem_arbiter: directed scenarios on a LATENCY=2 and a
// LATENCY=0 instance, then a randomized run against a transaction-level model.
module tb_pmem_arbiter;
    localparam int LatA  = 2;
    localparam int NRand = 1500;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic mem_clear = 1'b1;
    int   cyc       = 0;
    int   total     = 0;
    int   bad       = 0;

    pmem_arbiter_if ifa ();
    pmem_arbiter_if ifb ();

    pmem_arbiter #(.LATENCY(LatA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pmem_arbiter #(.LATENCY(0))    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: combinational read, byte-masked write on the strobe edge.
    logic [31:0] mem_a   [4096];
    logic [31:0] mem_b   [4096];
    logic [31:0] ref_mem [4096];

    assign ifa.mem_rdata = mem_a[ifa.mem_raddr[13:2]];
    assign ifb.mem_rdata = mem_b[ifb.mem_raddr[13:2]];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 4096; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            mem_a[0] <= 32'h0000_0413;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ifa.mem_valid && ifa.mem_wen && ifa.mem_wmask[b])
                    mem_a[ifa.mem_waddr[13:2]][8*b +: 8] <= ifa.mem_wdata[8*b +: 8];
                if (ifb.mem_valid && ifb.mem_wen && ifb.mem_wmask[b])
                    mem_b[ifb.mem_waddr[13:2]][8*b +: 8] <= ifb.mem_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = 32'h8000_0000;
        a[7:2] = 6'($urandom_range(0, 63));
        a[1:0] = 2'($urandom_range(0, 3));
        return a;
    endfunction

    task automatic idle_inputs();
        ifa.ifu_req_valid = 1'b0; ifa.ifu_req_addr = '0; ifa.ifu_resp_ready = 1'b1;
        ifa.lsu_req_valid = 1'b0; ifa.lsu_req_wen = 1'b0; ifa.lsu_req_addr = '0;
        ifa.lsu_req_wdata = '0;   ifa.lsu_req_wmask = '0; ifa.lsu_resp_ready = 1'b1;
        ifb.ifu_req_valid = 1'b0; ifb.ifu_req_addr = '0; ifb.ifu_resp_ready = 1'b1;
        ifb.lsu_req_valid = 1'b0; ifb.lsu_req_wen = 1'b0; ifb.lsu_req_addr = '0;
        ifb.lsu_req_wdata = '0;   ifb.lsu_req_wmask = '0; ifb.lsu_resp_ready = 1'b1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    // One isolated transaction on the LATENCY=2 instance, checked cycle by cycle.
    task automatic txn_a(input logic lsu, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wmask,
                         input logic [31:0] exp_data, input string tag);
        if (lsu) begin
            ifa.lsu_req_valid = 1'b1; ifa.lsu_req_wen = wen; ifa.lsu_req_addr = addr;
            ifa.lsu_req_wdata = wdata; ifa.lsu_req_wmask = wmask;
        end else begin
            ifa.ifu_req_valid = 1'b1; ifa.ifu_req_addr = addr;
        end
        #1;
        check({tag, "/ready"}, lsu ? ifa.lsu_req_ready : ifa.ifu_req_ready, 1'b1);
        step();
        ifa.ifu_req_valid = 1'b0;
        ifa.lsu_req_valid = 1'b0;
        #1;
        for (int k = 0; k < LatA; k++) begin
            check({tag, "/wait_nomem"}, ifa.mem_valid, 1'b0);
            step(); #1;
        end
        check({tag, "/mem_valid"}, ifa.mem_valid, 1'b1);
        check({tag, "/mem_wen"},   ifa.mem_wen, wen);
        check({tag, "/mem_raddr"}, ifa.mem_raddr, addr);
        check({tag, "/mem_waddr"}, ifa.mem_waddr, addr);
        if (lsu) begin
            check({tag, "/mem_wdata"}, ifa.mem_wdata, wdata);
            check({tag, "/mem_wmask"}, ifa.mem_wmask, {4'b0000, wmask});
        end
        if (wen) ref_mem[addr[13:2]] = merge(ref_mem[addr[13:2]], wdata, wmask);
        step(); #1;
        check({tag, "/mem_off"}, ifa.mem_valid, 1'b0);
        check({tag, "/rv_own"}, lsu ? ifa.lsu_resp_valid : ifa.ifu_resp_valid, 1'b1);
        check({tag, "/rv_other"}, lsu ? ifa.ifu_resp_valid : ifa.lsu_resp_valid, 1'b0);
        check({tag, "/data"}, lsu ? ifa.lsu_resp_data : ifa.ifu_resp_data, exp_data);
        step(); #1;
        check({tag, "/rv_done"}, lsu ? ifa.lsu_resp_valid : ifa.ifu_resp_valid, 1'b0);
    endtask

    int   acc[$];
    int   memv[$];
    int   rv[$];
    int   grants[$];
    logic busy, own_lsu, last_lsu, exp_wen, g_lsu, ea_i, ea_l, em, erv;
    logic pend_i, pend_l, pl_wen;
    int   t_acc;
    logic [31:0] exp_addr, exp_wdata, exp_rdata, pi_addr, pl_addr, pl_wdata;
    logic [3:0]  exp_wmask, pl_wmask;

    initial begin
        idle_inputs();
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        ref_mem[0] = 32'h0000_0413;
        step(); step();
        mem_clear = 1'b0;
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst/ifu_rv", ifa.ifu_resp_valid, 1'b0);
        check("rst/lsu_rv", ifa.lsu_resp_valid, 1'b0);
        check("rst/mem_valid", ifa.mem_valid, 1'b0);
        check("rst/mem_raddr", ifa.mem_raddr, 32'h0);
        check("rst/mem_wmask", ifa.mem_wmask, 8'h0);
        check("rst/b_mem_valid", ifb.mem_valid, 1'b0);
        ifa.lsu_req_valid = 1'b1;
        #1;
        check("rst/lsu_ready", ifa.lsu_req_ready, 1'b1);
        check("rst/ifu_not_ready", ifa.ifu_req_ready, 1'b0);
        ifa.lsu_req_valid = 1'b0;
        #1;

        // Directed single transactions
        txn_a(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0000_0413, "ifu_rd");
        txn_a(1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011, 32'h0, "lsu_wr");
        txn_a(1'b1, 1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0000_BEEF, "lsu_rd");

        // Response backpressure with a competing LSU request held off
        ifa.ifu_req_valid = 1'b1; ifa.ifu_req_addr = 32'h8000_0000;
        #1;
        check("bp/ifu_ready", ifa.ifu_req_ready, 1'b1);
        step();
        ifa.ifu_req_valid = 1'b0; ifa.ifu_resp_ready = 1'b0;
        ifa.lsu_req_valid = 1'b1; ifa.lsu_req_wen = 1'b0; ifa.lsu_req_addr = 32'h8000_1000;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("bp/lsu_held_pre", ifa.lsu_req_ready, 1'b0);
            step(); #1;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp/rv_stable", ifa.ifu_resp_valid, 1'b1);
            check("bp/data_stable", ifa.ifu_resp_data, 32'h0000_0413);
            check("bp/lsu_held", ifa.lsu_req_ready, 1'b0);
            step(); #1;
        end
        ifa.ifu_resp_ready = 1'b1;
        #1;
        check("bp/rv_at_hs", ifa.ifu_resp_valid, 1'b1);
        step(); #1;
        check("bp/rv_after_hs", ifa.ifu_resp_valid, 1'b0);
        check("bp/lsu_accept", ifa.lsu_req_ready, 1'b1);
        step();
        ifa.lsu_req_valid = 1'b0;
        for (int k = 0; k < LatA + 1; k++) step();
        #1;
        check("bp/lsu_rv", ifa.lsu_resp_valid, 1'b1);
        check("bp/lsu_data", ifa.lsu_resp_data, 32'h0000_BEEF);
        step();

        // Round robin with both masters continuously valid after reset
        pulse_reset();
        ifa.ifu_req_valid = 1'b1; ifa.ifu_req_addr = 32'h8000_0000;
        ifa.lsu_req_valid = 1'b1; ifa.lsu_req_wen = 1'b0; ifa.lsu_req_addr = 32'h8000_1000;
        for (int k = 0; k < 40 && grants.size() < 4; k++) begin
            #1;
            check("rr/excl", ifa.ifu_req_ready && ifa.lsu_req_ready, 1'b0);
            if (ifa.ifu_req_ready) grants.push_back(0);
            else if (ifa.lsu_req_ready) grants.push_back(1);
            step();
        end
        ifa.ifu_req_valid = 1'b0; ifa.lsu_req_valid = 1'b0;
        check("rr/count", grants.size(), 4);
        if (grants.size() == 4)
            for (int i = 0; i < 4; i++) check("rr/order", grants[i], i % 2);
        for (int k = 0; k < LatA + 3; k++) step();

        // Reset during WAIT: no strobe may ever appear
        ifa.ifu_req_valid = 1'b1; ifa.ifu_req_addr = 32'h8000_0000;
        #1;
        check("rw/accept", ifa.ifu_req_ready, 1'b1);
        step();
        ifa.ifu_req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rw/no_mem", ifa.mem_valid, 1'b0);
            step(); #1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < LatA + 3; k++) begin
            #1;
            check("rw/no_mem_after", ifa.mem_valid, 1'b0);
            check("rw/no_rv", ifa.ifu_resp_valid, 1'b0);
            step();
        end
        ifa.ifu_req_valid = 1'b1;
        #1;
        check("rw/idle_ready", ifa.ifu_req_ready, 1'b1);
        ifa.ifu_req_valid = 1'b0;
        step();

        // Reset during ACCESS: strobe drops without waiting for a clock
        ifa.lsu_req_valid = 1'b1; ifa.lsu_req_wen = 1'b0; ifa.lsu_req_addr = 32'h8000_0000;
        #1;
        check("ra/accept", ifa.lsu_req_ready, 1'b1);
        step();
        ifa.lsu_req_valid = 1'b0;
        for (int k = 0; k < LatA; k++) step();
        #1;
        check("ra/mem_on", ifa.mem_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ra/mem_async_off", ifa.mem_valid, 1'b0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ra/no_rv", ifa.lsu_resp_valid, 1'b0);
            check("ra/no_mem", ifa.mem_valid, 1'b0);
            step();
        end
        ifa.lsu_req_valid = 1'b1;
        #1;
        check("ra/idle_ready", ifa.lsu_req_ready, 1'b1);
        ifa.lsu_req_valid = 1'b0;
        step();

        // LATENCY=0 instance: write, then back-to-back reads
        ifb.lsu_req_valid = 1'b1; ifb.lsu_req_wen = 1'b1; ifb.lsu_req_addr = 32'h8000_0040;
        ifb.lsu_req_wdata = 32'hCAFE_F00D; ifb.lsu_req_wmask = 4'hF;
        #1;
        check("l0/wr_ready", ifb.lsu_req_ready, 1'b1);
        step();
        ifb.lsu_req_valid = 1'b0;
        #1;
        check("l0/wr_mem", ifb.mem_valid, 1'b1);
        check("l0/wr_wen", ifb.mem_wen, 1'b1);
        check("l0/wr_waddr", ifb.mem_waddr, 32'h8000_0040);
        step(); #1;
        check("l0/wr_rv", ifb.lsu_resp_valid, 1'b1);
        check("l0/wr_data", ifb.lsu_resp_data, 32'h0);
        step();
        ifb.lsu_req_valid = 1'b1; ifb.lsu_req_wen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (ifb.lsu_req_ready) acc.push_back(cyc);
            if (ifb.mem_valid) memv.push_back(cyc);
            if (ifb.lsu_resp_valid) begin
                rv.push_back(cyc);
                check("l0/rd_data", ifb.lsu_resp_data, 32'hCAFE_F00D);
            end
            step();
        end
        ifb.lsu_req_valid = 1'b0;
        check("l0/n_accepts", acc.size() >= 3 && memv.size() >= 1 && rv.size() >= 1, 1'b1);
        if (acc.size() >= 3 && memv.size() >= 1 && rv.size() >= 1) begin
            check("l0/period0", acc[1] - acc[0], 3);
            check("l0/period1", acc[2] - acc[1], 3);
            check("l0/access_lat", memv[0] - acc[0], 1);
            check("l0/resp_lat", rv[0] - acc[0], 2);
        end
        for (int k = 0; k < 4; k++) step();

        // Randomized traffic against a transaction-level model
        pulse_reset();
        busy = 1'b0; own_lsu = 1'b0; last_lsu = 1'b1; t_acc = 0;
        pend_i = 1'b0; pend_l = 1'b0; pi_addr = '0;
        pl_addr = '0; pl_wdata = '0; pl_wmask = '0; pl_wen = 1'b0;
        exp_addr = '0; exp_wdata = '0; exp_wmask = '0; exp_wen = 1'b0; exp_rdata = '0;
        for (int n = 0; n < NRand; n++) begin
            if (!pend_i && $urandom_range(0, 2) == 0) begin
                pend_i = 1'b1; pi_addr = rand_addr();
            end
            if (!pend_l && $urandom_range(0, 2) == 0) begin
                pend_l = 1'b1; pl_addr = rand_addr(); pl_wen = ($urandom_range(0, 1) == 1);
                pl_wdata = $urandom(); pl_wmask = 4'($urandom_range(0, 15));
            end
            ifa.ifu_req_valid = pend_i; ifa.ifu_req_addr = pi_addr;
            ifa.lsu_req_valid = pend_l; ifa.lsu_req_addr = pl_addr; ifa.lsu_req_wen = pl_wen;
            ifa.lsu_req_wdata = pl_wdata; ifa.lsu_req_wmask = pl_wmask;
            ifa.ifu_resp_ready = ($urandom_range(0, 1) == 1);
            ifa.lsu_resp_ready = ($urandom_range(0, 1) == 1);
            #1;
            g_lsu = (pend_i && pend_l) ? !last_lsu : pend_l;
            ea_i  = !busy && pend_i && !g_lsu;
            ea_l  = !busy && pend_l && g_lsu;
            check("rnd/acc_ifu", ifa.ifu_req_valid && ifa.ifu_req_ready, ea_i);
            check("rnd/acc_lsu", ifa.lsu_req_valid && ifa.lsu_req_ready, ea_l);
            check("rnd/excl", ifa.ifu_req_ready && ifa.lsu_req_ready, 1'b0);
            em = busy && (cyc == t_acc + LatA + 1);
            check("rnd/mem_valid", ifa.mem_valid, em);
            if (em) begin
                check("rnd/mem_raddr", ifa.mem_raddr, exp_addr);
                check("rnd/mem_waddr", ifa.mem_waddr, exp_addr);
                check("rnd/mem_wen", ifa.mem_wen, exp_wen);
                if (own_lsu) begin
                    check("rnd/mem_wdata", ifa.mem_wdata, exp_wdata);
                    check("rnd/mem_wmask", ifa.mem_wmask, {4'b0000, exp_wmask});
                end
            end
            erv = busy && (cyc >= t_acc + LatA + 2);
            check("rnd/rv_ifu", ifa.ifu_resp_valid, erv && !own_lsu);
            check("rnd/rv_lsu", ifa.lsu_resp_valid, erv && own_lsu);
            if (erv)
                check("rnd/data", own_lsu ? ifa.lsu_resp_data : ifa.ifu_resp_data, exp_rdata);
            if (erv && (own_lsu ? ifa.lsu_resp_ready : ifa.ifu_resp_ready)) busy = 1'b0;
            if (ea_i || ea_l) begin
                busy = 1'b1; t_acc = cyc; own_lsu = ea_l; last_lsu = ea_l;
                exp_addr  = ea_l ? pl_addr : pi_addr;
                exp_wen   = ea_l && pl_wen;
                exp_wdata = pl_wdata;
                exp_wmask = pl_wmask;
                if (exp_wen) begin
                    exp_rdata = '0;
                    ref_mem[exp_addr[13:2]] = merge(ref_mem[exp_addr[13:2]], pl_wdata, pl_wmask);
                end else begin
                    exp_rdata = ref_mem[exp_addr[13:2]];
                end
                if (ea_l) pend_l = 1'b0;
                else pend_i = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
